// File: rtl/axi_read_master.sv
// AXI4 single-burst read initiator: drives AR, forwards R beats downstream,
// and flags error responses and RLAST/beat-count disagreement.
module axi_read_master #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MAX_SIZE      = $clog2(DATA_WIDTH / 8)
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [7:0]               cmd_len,
    input  logic [2:0]               cmd_size,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    output logic [ADDRESS_WIDTH-1:0] araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     resp_err,
    output logic                     last_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    state_t                   r_state;
    logic [ADDRESS_WIDTH-1:0] r_araddr;
    logic [7:0]               r_arlen;
    logic [2:0]               r_arsize;
    logic                     r_arvalid;
    logic [8:0]               r_beats;
    logic                     r_done;
    logic                     r_resp_err;
    logic                     r_last_err;

    logic       w_in_data;
    logic       w_beat;
    logic       w_final;
    logic [2:0] w_size;

    assign w_in_data = (r_state == S_DATA);
    assign w_beat    = w_in_data && rvalid && out_ready;
    assign w_final   = (r_beats == 9'd1);
    assign w_size    = (cmd_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : cmd_size;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state    <= S_IDLE;
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_arsize   <= '0;
            r_arvalid  <= 1'b0;
            r_beats    <= '0;
            r_done     <= 1'b0;
            r_resp_err <= 1'b0;
            r_last_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_araddr   <= cmd_addr;
                        r_arlen    <= cmd_len;
                        r_arsize   <= w_size;
                        r_beats    <= {1'b0, cmd_len} + 9'd1;
                        r_resp_err <= 1'b0;
                        r_last_err <= 1'b0;
                        r_arvalid  <= 1'b1;
                        r_state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        r_beats <= r_beats - 9'd1;
                        if (rresp != 2'b00) r_resp_err <= 1'b1;
                        if (rlast != w_final) r_last_err <= 1'b1;
                        // Early rlast only flags; the burst ends on the count.
                        if (w_final) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign araddr    = r_araddr;
    assign arlen     = r_arlen;
    assign arsize    = r_arsize;
    assign arburst   = 2'b01;
    assign arvalid   = r_arvalid;
    assign rready    = w_in_data && out_ready;
    assign out_valid = w_in_data && rvalid;
    assign out_data  = rdata;
    assign out_last  = w_in_data && w_final;
    assign done      = r_done;
    assign resp_err  = r_resp_err;
    assign last_err  = r_last_err;

endmodule

// File: tb/tb_axi_read_master.sv
// Scoreboard bench for axi_read_master: randomized AXI slave and downstream
// sink, expectations derived per burst from the command and planned beats.
module tb_axi_read_master;

    logic        aclk = 1'b0;
    logic        areset;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        resp_err;
    logic        last_err;

    axi_read_master dut (
        .aclk      (aclk),
        .areset    (areset),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_size  (cmd_size),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .resp_err  (resp_err),
        .last_err  (last_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] len;
        logic [2:0] size;
    } ar_t;

    typedef struct {
        logic [31:0] d;
        logic        last;
    } out_t;

    typedef struct {
        logic re;
        logic le;
    } flag_t;

    beat_t plan_q[$];
    int    plan_cnt_q[$];
    ar_t   ar_exp_q[$];
    out_t  out_exp_q[$];
    flag_t flag_exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int bp_mode     = 0;
    int r_gap       = 0;
    bit ar_en       = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic finish_sim();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    // AXI slave: AR acceptance and R beat delivery
    initial begin
        beat_t act_q[$];
        bit    r_hs;
        bit    ar_hs;
        int    n;
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = '0;
        rlast   = 1'b0;
        forever begin
            @(negedge aclk);
            r_hs  = rvalid && rready;
            ar_hs = arvalid && arready;
            if (ar_hs && plan_cnt_q.size() > 0) begin
                n = plan_cnt_q.pop_front();
                repeat (n) act_q.push_back(plan_q.pop_front());
            end
            @(posedge aclk);
            #1;
            if (r_hs && act_q.size() > 0) void'(act_q.pop_front());
            arready = ar_en && ($urandom_range(0, 2) != 0);
            if (act_q.size() > 0) begin
                if (!(rvalid && !r_hs))
                    rvalid = (r_gap == 0) || ($urandom_range(0, 3) != 0);
                rdata = act_q[0].d;
                rresp = act_q[0].resp;
                rlast = act_q[0].last;
            end else begin
                rvalid = ($urandom_range(0, 4) == 0);
                rdata  = $urandom;
                rresp  = 2'($urandom);
                rlast  = 1'($urandom);
            end
        end
    end

    // Downstream sink backpressure
    initial begin
        int k;
        k = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            k++;
        end
    end

    // Monitor: compares DUT outputs against the scoreboard queues
    initial begin
        bit    in_data;
        bit    done_due;
        int    left;
        out_t  e;
        ar_t   a;
        flag_t f;
        in_data  = 1'b0;
        done_due = 1'b0;
        left     = 0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                in_data  = 1'b0;
                done_due = 1'b0;
                continue;
            end
            if (done_due || done) begin
                chk("done", done, done_due);
                if (done_due) begin
                    chk("busy_at_done", busy, 0);
                    if (flag_exp_q.size() == 0) begin
                        chk("flag_q_empty", 1, 0);
                    end else begin
                        f = flag_exp_q.pop_front();
                        chk("resp_err", resp_err, f.re);
                        chk("last_err", last_err, f.le);
                    end
                end
            end
            done_due = 1'b0;
            if (in_data) begin
                chk("rready_tracks", rready, out_ready);
                chk("out_valid_tracks", out_valid, rvalid);
                if (rvalid && out_ready) begin
                    if (out_exp_q.size() == 0) begin
                        chk("out_q_empty", 1, 0);
                    end else begin
                        e = out_exp_q.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_last", out_last, e.last);
                    end
                    left--;
                    if (left == 0) begin
                        in_data  = 1'b0;
                        done_due = 1'b1;
                    end
                end
            end else begin
                chk("idle_out_valid", out_valid, 0);
                chk("idle_rready", rready, 0);
            end
            if (arvalid && arready) begin
                if (ar_exp_q.size() == 0) begin
                    chk("ar_q_empty", 1, 0);
                end else begin
                    a = ar_exp_q.pop_front();
                    chk("araddr", araddr, a.addr);
                    chk("arlen", arlen, a.len);
                    chk("arsize", arsize, a.size);
                    chk("arburst", arburst, 1);
                    in_data = 1'b1;
                    left    = int'(a.len) + 1;
                end
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] l,
                        input logic [2:0] s);
        int t;
        t = 0;
        @(posedge aclk);
        #1;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = s;
        cmd_valid = 1'b1;
        do begin
            @(negedge aclk);
            t++;
        end while (!cmd_ready && t < 50);
        @(posedge aclk);
        #1;
        cmd_valid = 1'b0;
        if (t >= 50) begin
            chk("cmd_timeout", 1, 0);
            finish_sim();
        end
    endtask

    // mode 0: byte-ramp data; 1: error resp on last; 2: early rlast;
    // 3: rlast never set; 4: fully random beats
    task automatic run_burst(input logic [7:0] a, input logic [7:0] l,
                             input logic [2:0] s, input int mode);
        beat_t      b;
        logic [7:0] base;
        bit         re;
        bit         le;
        int         t;
        re = 1'b0;
        le = 1'b0;
        plan_cnt_q.push_back(int'(l) + 1);
        for (int i = 0; i <= int'(l); i++) begin
            base   = a + 8'(4 * i);
            b.d    = {base + 8'd3, base + 8'd2, base + 8'd1, base};
            b.resp = 2'b00;
            b.last = (i == int'(l));
            case (mode)
                1: b.resp = (i == int'(l)) ? 2'b10 : 2'b00;
                2: b.last = (i == int'(l) - 1);
                3: b.last = 1'b0;
                4: begin
                    b.d = $urandom;
                    b.resp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
                    if ($urandom_range(0, 6) == 0) b.last = ~b.last;
                end
                default: ;
            endcase
            plan_q.push_back(b);
            out_exp_q.push_back('{b.d, (i == int'(l))});
            if (b.resp != 2'b00) re = 1'b1;
            if (b.last != (i == int'(l))) le = 1'b1;
        end
        ar_exp_q.push_back('{a, l, (s > 3'd2) ? 3'd2 : s});
        flag_exp_q.push_back('{re, le});
        send(a, l, s);
        @(negedge aclk);
        chk("clr_resp_err", resp_err, 0);
        chk("clr_last_err", last_err, 0);
        chk("busy_addr", busy, 1);
        t = 0;
        while (!done && t < 3000) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 3000) begin
            chk("done_timeout", 1, 0);
            finish_sim();
        end
    endtask

    initial begin
        areset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_size  = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_last_err", last_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        chk("rst_arsize", arsize, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;

        // reset while the AR request is outstanding
        @(posedge aclk);
        #1;
        cmd_addr  = 8'h40;
        cmd_len   = 8'd5;
        cmd_size  = 3'd2;
        cmd_valid = 1'b1;
        @(posedge aclk);
        #1;
        cmd_valid = 1'b0;
        @(negedge aclk);
        chk("addr_arvalid", arvalid, 1);
        chk("addr_busy", busy, 1);
        chk("addr_cmd_ready", cmd_ready, 0);
        #2;
        areset = 1'b1;
        #1;
        chk("async_arvalid", arvalid, 0);
        chk("async_busy", busy, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_arvalid", arvalid, 0);
        ar_en = 1'b1;

        bp_mode = 0;
        r_gap   = 0;
        run_burst(8'h10, 8'd3, 3'd2, 0);
        bp_mode = 1;
        run_burst(8'h10, 8'd3, 3'd2, 0);
        r_gap   = 1;
        bp_mode = 0;
        run_burst(8'h20, 8'd1, 3'd2, 1);
        repeat (2) @(negedge aclk);
        chk("resp_err_held", resp_err, 1);
        run_burst(8'h30, 8'd2, 3'd2, 2);
        run_burst(8'h34, 8'd0, 3'd2, 3);
        run_burst(8'h50, 8'd0, 3'd5, 0);

        bp_mode = 2;
        for (int i = 0; i < 40; i++) begin
            run_burst(8'($urandom), 8'($urandom_range(0, 12)),
                      3'($urandom_range(0, 7)), int'($urandom_range(0, 4)));
        end

        repeat (5) @(negedge aclk);
        chk("out_q_leftover", out_exp_q.size(), 0);
        chk("flag_q_leftover", flag_exp_q.size(), 0);
        finish_sim();
    end

endmodule
